// File: rtl/irda_rx_deserializer_pkg.sv
// irda_pkg: shared FSM states and frame constants for the IrDA SIR receiver
package irda_pkg;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  localparam int OVERSAMPLE = 16;
  localparam int DATA_BITS = 8;
  localparam int NIBBLE_W = 4;
endpackage

// File: rtl/irda_rx_deserializer_if.sv
// irda_rx_deserializer_if: raw IR input plus decoded byte/nibble outputs
interface irda_rx_deserializer_if;
  import irda_pkg::*;
  logic ir_rxd;
  logic [DATA_BITS-1:0] rx_byte;
  logic rx_valid;
  logic frame_err;
  logic [NIBBLE_W-1:0] hex_hi;
  logic [NIBBLE_W-1:0] hex_lo;
  logic busy;
  modport master(output ir_rxd, input rx_byte, rx_valid, frame_err, hex_hi, hex_lo, busy);
  modport slave(input ir_rxd, output rx_byte, rx_valid, frame_err, hex_hi, hex_lo, busy);
endinterface

// File: rtl/irda_rx_deserializer_tick_gen.sv
// irda_tick_gen: oversample tick every DIV clocks, restartable by clr
module irda_tick_gen #(
  parameter int DIV = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);
  localparam int W = $clog2(DIV);
  logic [W-1:0] cnt;
  assign tick = (cnt == W'(DIV - 1)) && !clr;
  // wrap after DIV-1, or restart so the next tick lands DIV clocks after clr
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt <= '0;
    else cnt <= (clr || tick) ? '0 : cnt + 1'b1;
endmodule

// File: rtl/irda_rx_deserializer.sv
// irda_rx_deserializer: IrDA SIR 8N1 receiver feeding two nibble decoders; optional IRDA_RX_GLITCH_FILTER_EN
module irda_rx_deserializer
  import irda_pkg::*;
#(
  parameter int CLK_HZ = 50000000,
  parameter int BAUD = 9600,
  parameter int SYNC_STAGES = 2,
  parameter int MIN_PULSE_CYCLES = 4
) (
  input logic clk,
  input logic rst,
  irda_rx_deserializer_if.slave bus
);
  localparam int DIV = CLK_HZ / (BAUD * OVERSAMPLE);
  localparam int SW = $clog2(OVERSAMPLE);
  localparam int IW = $clog2(DATA_BITS);
  state_t state, state_nx;
  logic [SYNC_STAGES-1:0] sync;
  logic synced, pulse, start_ev, tick, win_end, flag, bit_val;
  logic [SW-1:0] sub;
  logic [IW-1:0] idx;
  logic [DATA_BITS-1:0] shift, rx_byte;
  logic [NIBBLE_W-1:0] hex_hi, hex_lo;
  logic rx_valid, frame_err;
  assign synced = sync[SYNC_STAGES-1];
  // synchroniser starts at the idle-high level so reset never fakes an edge
  always_ff @(posedge clk or posedge rst)
    if (rst) sync <= '1;
    else sync <= {sync[SYNC_STAGES-2:0], bus.ir_rxd};
`ifdef IRDA_RX_GLITCH_FILTER_EN
  localparam int LW = $clog2(MIN_PULSE_CYCLES + 1);
  logic [LW-1:0] low_cnt;
  assign pulse = !synced && (low_cnt == LW'(MIN_PULSE_CYCLES - 1));
  // count consecutive low clocks, saturating so one low period fires once
  always_ff @(posedge clk or posedge rst)
    if (rst) low_cnt <= '0;
    else low_cnt <= synced ? '0 : (low_cnt == LW'(MIN_PULSE_CYCLES)) ? low_cnt : low_cnt + 1'b1;
`else
  localparam int unused_min_pulse = MIN_PULSE_CYCLES;
  logic prev;
  assign pulse = prev && !synced;
  // previous synced level for falling-edge detection
  always_ff @(posedge clk or posedge rst)
    if (rst) prev <= 1'b1;
    else prev <= synced;
`endif
  assign start_ev = (state == IDLE) && pulse;
  assign win_end = tick && (sub == SW'(OVERSAMPLE - 1));
  assign bit_val = !(flag || pulse);
  irda_tick_gen #(.DIV(DIV)) u_tick (.clk(clk), .rst(rst), .clr(start_ev), .tick(tick));
  // state register
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_nx;
  // frame sequencing: start window, eight data windows, one stop window
  always_comb begin
    state_nx = state;
    state_nx = start_ev ? START :
               (state == START && win_end) ? DATA :
               (state == DATA && win_end && idx == IW'(DATA_BITS - 1)) ? STOP :
               (state == STOP && win_end) ? IDLE : state;
  end
  // window counters, pulse flag, shift register and output strobes
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      sub <= '0;
      idx <= '0;
      flag <= 1'b0;
      shift <= '0;
      rx_byte <= '0;
      hex_hi <= '0;
      hex_lo <= '0;
      rx_valid <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      sub <= (start_ev || win_end) ? '0 : tick ? sub + 1'b1 : sub;
      idx <= (state == START) ? '0 : (state == DATA && win_end) ? idx + 1'b1 : idx;
      flag <= (win_end || state == IDLE) ? 1'b0 : flag || (pulse && (state == DATA || state == STOP));
      if (state == DATA && win_end) shift <= {bit_val, shift[DATA_BITS-1:1]};
      rx_valid <= (state == STOP) && win_end && bit_val;
      frame_err <= (state == STOP) && win_end && !bit_val;
      if (state == STOP && win_end && bit_val) begin
        rx_byte <= shift;
        hex_hi <= shift[DATA_BITS-1:NIBBLE_W];
        hex_lo <= shift[NIBBLE_W-1:0];
      end
    end
  assign bus.rx_byte = rx_byte;
  assign bus.hex_hi = hex_hi;
  assign bus.hex_lo = hex_lo;
  assign bus.rx_valid = rx_valid;
  assign bus.frame_err = frame_err;
  assign bus.busy = state != IDLE;
endmodule

// File: doc/irda_rx_deserializer.md
Name: irda_rx_deserializer

Overview:
- IrDA SIR receive front end. Sits directly upstream of the 7-segment nibble decoders.
- Synchronises the raw active-low IR transceiver RXD pulse stream and recovers 8N1 frames from it.
- Publishes each good byte as a one-cycle strobe plus two held nibbles (hex_hi, hex_lo). Each nibble drives one digit decoder.

Parameters:
- CLK_HZ, 50000000, system clock frequency in Hz.
- BAUD, 9600, SIR bit rate; oversample divider DIV = CLK_HZ/(BAUD*16), integer division, must be >= 2.
- SYNC_STAGES, 2, flip-flop depth of the ir_rxd synchroniser (>= 2).
- MIN_PULSE_CYCLES, 4, qualification length; used only when IRDA_RX_GLITCH_FILTER_EN is defined.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- ir_rxd  in  1  raw transceiver output, asynchronous; low pulse = SIR '0', idle high.
- rx_byte  out  8  last good byte, held.
- rx_valid  out  1  one-cycle strobe, rx_byte/hex_* updated this cycle.
- frame_err  out  1  one-cycle strobe, stop window contained a pulse.
- hex_hi  out  4  rx_byte[7:4], held.
- hex_lo  out  4  rx_byte[3:0], held.
- busy  out  1  high while a frame is in progress (state != IDLE).

Behaviour:
- Reset (async, active-high): all outputs 0. State IDLE, counters 0, synchroniser preset to 1 (idle line). Reset mid-frame aborts the frame with no strobe.
- Input path: SYNC_STAGES-deep synchroniser. A pulse event is a qualified falling edge of the synced signal (previous 1, current 0), one clock wide. A long low level yields exactly one event.
- Tick generator: counter 0..DIV-1, tick when counter = DIV-1. The counter is cleared on the start event so windows align to the start pulse. Tick count per bit = 16.
- Window: 16 ticks. A sticky flag is set by any pulse event inside the window and cleared at window end. Bit value = ~flag (pulse -> 0, none -> 1).
- FSM states and transitions:
  - IDLE: a pulse event moves to START; tick counter and subwindow counter cleared; the start pulse counts as the start bit.
  - START: wait 16 ticks, then go to DATA; bit index 0.
  - DATA: 8 windows, LSB first, shifted into a shift register; after the 8th window go to STOP.
  - STOP: 1 window.
    - End with flag clear: rx_byte <= shift, hex_hi/hex_lo updated, rx_valid = 1 for exactly that cycle.
    - End with flag set: frame_err = 1 for that cycle; rx_byte/hex_* hold their previous value.
    - Either way, return to IDLE on the next cycle.
- Pulse events during START (after the initiating edge) are ignored.
- Events in the last cycle of a window belong to that window.
- An event in the final STOP cycle counts toward the stop flag and does not start a new frame.
- Back-to-back frames: a pulse event in the first IDLE cycle after STOP starts the next frame with no lost cycles.
- rx_valid and frame_err are never high in the same cycle.
- Latency: rx_valid asserts 10*16*DIV clocks (+/- 1) after the synced start edge, plus SYNC_STAGES clocks of input delay.

Optional Feature:
- Macro IRDA_RX_GLITCH_FILTER_EN.
- Defined: a pulse event fires only after the synced input has been low for MIN_PULSE_CYCLES consecutive clocks. It fires once per low period, on the cycle the count is reached. Shorter lows are discarded.
- Undefined: a single synced low cycle after a high cycle is a pulse event, and the MIN_PULSE_CYCLES parameter is unused.

Decomposition:
- Shared package irda_pkg:
  - state enum (IDLE, START, DATA, STOP);
  - OVERSAMPLE = 16;
  - DATA_BITS = 8;
  - nibble width constant = 4 (shared with the seven-segment decoder).
- One sub-module: irda_tick_gen (DIV counter with synchronous clear input, tick output).

Test Plan:
All scenarios use CLK_HZ=1600000 and BAUD=10000, giving DIV=10 and 160 clocks/bit; pulses are 30 clocks low.
- Reset: assert rst asynchronously mid-cycle -> all outputs 0 immediately, busy 0; release; 2000 idle clocks -> no strobes.
- Good frame 0xA5: pulses at start and at bits 1,3,4,6, none in the stop window -> rx_valid single cycle ~1600 clocks after start, rx_byte=0xA5, hex_hi=0xA, hex_lo=0x5, frame_err 0.
- Frame error: frame 0x3C with a pulse in the stop window -> frame_err one cycle, rx_valid 0, rx_byte still 0xA5, hex_hi/hex_lo still 0xA/0x5.
- Back-to-back: 0x00 then 0xFF with the next start edge one clock after STOP end -> two rx_valid strobes, values 0x00 then 0xFF, busy drops for 1 cycle only.
- Reset mid-frame: rst during DATA bit 4, release, send 0x81 -> no strobe for the aborted frame, rx_valid with 0x81.
- Glitch (macro defined, MIN_PULSE_CYCLES=4): 2-clock low spikes during IDLE -> busy stays 0; macro undefined -> same spike starts a frame (busy 1).
